// File: rtl/video_timing_monitor.sv
// video_timing_monitor: measures line/frame geometry of an rgb/de/skip/vs/hs stream and captures one pixel per frame.
// Latency: results publish on the clock edge after the vs rising-edge cycle.
// Backpressure: none; pure sink, every input cycle is observed.
// Ports: clk/reset_n; rgb, de, skip, vs, hs video input; sample_x/sample_y capture coordinate;
//        valid/changed status; frame_dots, frame_lines, active_px, active_lines geometry;
//        sample_rgb captured pixel; frame_count locked frames since lock.
module video_timing_monitor #(
  parameter int CW       = 12,
  parameter int TIMEOUT  = 4096,
  parameter int FRAME_CW = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [23:0]         rgb,
  input  logic                de,
  input  logic                skip,
  input  logic                vs,
  input  logic                hs,
  input  logic [CW-1:0]       sample_x,
  input  logic [CW-1:0]       sample_y,
  output logic                valid,
  output logic                changed,
  output logic [CW-1:0]       frame_dots,
  output logic [CW-1:0]       frame_lines,
  output logic [CW-1:0]       active_px,
  output logic [CW-1:0]       active_lines,
  output logic [23:0]         sample_rgb,
  output logic [FRAME_CW-1:0] frame_count
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t        state, state_nxt;
  logic          hs_q, vs_q;
  logic [CW-1:0] dot_cnt, line_len, line_cnt, px_cnt, px_max, act_cnt;
  logic          line_act;
  logic [23:0]   shadow;
  logic [TW-1:0] to_cnt;

  logic          hs_edge, vs_edge, pix, hit, timeout;
  logic          publish, lock_entry, drop;
  logic [CW-1:0] x_idx, y_idx, len_upd, line_upd, px_max_upd, act_upd;

  // hs work is folded in before vs so a coincident hs/vs edge closes the
  // ending line into this frame's totals; the *_upd values are what vs latches.
  always_comb begin
    hs_edge    = hs & ~hs_q;
    vs_edge    = vs & ~vs_q;
    pix        = de & ~skip;
    x_idx      = hs_edge ? '0 : px_cnt;
    len_upd    = hs_edge ? dot_cnt : line_len;
    line_upd   = hs_edge ? sat_inc(line_cnt) : line_cnt;
    px_max_upd = (hs_edge && (px_cnt > px_max)) ? px_cnt : px_max;
    act_upd    = (hs_edge && line_act) ? sat_inc(act_cnt) : act_cnt;
    // a pixel on the vs cycle belongs to the new frame, row 0
    y_idx      = vs_edge ? '0 : act_upd;
    hit        = pix && (x_idx == sample_x) && (y_idx == sample_y);
    timeout    = !hs_edge && (to_cnt == TO_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    publish    = 1'b0;
    lock_entry = 1'b0;
    drop       = 1'b0;
    if (timeout) begin
      state_nxt = SEARCH;
      drop      = 1'b1;
    end else if (vs_edge) begin
      case (state)
        SEARCH:  state_nxt = MEASURE;
        MEASURE: begin
          state_nxt  = LOCKED;
          publish    = 1'b1;
          lock_entry = 1'b1;
        end
        LOCKED:  publish = 1'b1;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      dot_cnt  <= '0;
      line_len <= '0;
      line_cnt <= '0;
      px_cnt   <= '0;
      px_max   <= '0;
      act_cnt  <= '0;
      line_act <= 1'b0;
      shadow   <= '0;
      to_cnt   <= '0;
    end else begin
      hs_q     <= hs;
      vs_q     <= vs;
      dot_cnt  <= hs_edge ? CW'(1) : sat_inc(dot_cnt);
      line_len <= len_upd;
      line_cnt <= vs_edge ? '0 : line_upd;
      px_cnt   <= pix ? sat_inc(x_idx) : x_idx;
      px_max   <= vs_edge ? '0 : px_max_upd;
      act_cnt  <= vs_edge ? '0 : act_upd;
      line_act <= (line_act & ~hs_edge) | pix;
      shadow   <= hit ? rgb : (vs_edge ? 24'h0 : shadow);
      // saturating, so a dead input keeps the block parked in SEARCH
      to_cnt   <= hs_edge ? '0 : ((to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid        <= 1'b0;
      changed      <= 1'b0;
      frame_dots   <= '0;
      frame_lines  <= '0;
      active_px    <= '0;
      active_lines <= '0;
      sample_rgb   <= '0;
      frame_count  <= '0;
    end else if (drop) begin
      valid       <= 1'b0;
      changed     <= 1'b0;
      frame_count <= '0;
    end else if (publish) begin
      valid        <= 1'b1;
      // the first locked frame has no predecessor to compare against
      changed      <= !lock_entry && ((len_upd != frame_dots) || (line_upd != frame_lines) ||
                                      (px_max_upd != active_px) || (act_upd != active_lines));
      frame_dots   <= len_upd;
      frame_lines  <= line_upd;
      active_px    <= px_max_upd;
      active_lines <= act_upd;
      sample_rgb   <= shadow;
      frame_count  <= lock_entry ? FRAME_CW'(1) : frame_count + 1'b1;
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_monitor.sv
module tb_video_timing_monitor;
  localparam int CW  = 12;
  localparam int FCW = 16;
  localparam int DX0 = 8;   // first de column of a line
  localparam int DY0 = 4;   // first de line of a frame

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [23:0]    rgb = '0;
  logic           de = 1'b0, skip = 1'b0, vs = 1'b0, hs = 1'b0;
  logic [CW-1:0]  sample_x = '0, sample_y = '0;
  logic           valid, changed;
  logic [CW-1:0]  frame_dots, frame_lines, active_px, active_lines;
  logic [23:0]    sample_rgb;
  logic [FCW-1:0] frame_count;

  always #5 clk = ~clk;

  video_timing_monitor #(.CW(CW), .TIMEOUT(4096), .FRAME_CW(FCW)) dut (
    .clk(clk), .reset_n(reset_n), .rgb(rgb), .de(de), .skip(skip), .vs(vs), .hs(hs),
    .sample_x(sample_x), .sample_y(sample_y), .valid(valid), .changed(changed),
    .frame_dots(frame_dots), .frame_lines(frame_lines), .active_px(active_px),
    .active_lines(active_lines), .sample_rgb(sample_rgb), .frame_count(frame_count)
  );

  typedef struct { int xd; int yd; int aw; int ah; bit skp; int sx; int sy; } fp_t;
  typedef struct packed { logic [11:0] dots; logic [11:0] lines; logic [11:0] apx; logic [11:0] alines; logic [23:0] smp; } res_t;

  int   tests = 0, fails = 0;
  int   frames_seen = 0;   // vs edges since reset / lock loss
  res_t exp_r = '0;
  bit   exp_valid = 0, exp_chg = 0;
  int   exp_fc = 0;
  fp_t  prev_fp, base;
  int   gen_px = 0, hs_w = 1, vs_w = 1;

  // Test image: grey square around the centre of a 24x20 area, elsewhere
  // white xor'ed with the coordinate so every pixel is distinct.
  function automatic logic [23:0] pattern(input int x, input int y);
    logic [11:0] xx, yy;
    xx = 12'(x);
    yy = 12'(y);
    if (x >= 10 && x < 14 && y >= 8 && y < 12) return 24'h808080;
    return 24'hFFFFFF ^ {xx, yy};
  endfunction

  // Result set a correct monitor reports for a frame of geometry p.
  function automatic res_t model_frame(input fp_t p);
    res_t r;
    r.dots   = 12'(p.xd);
    r.lines  = 12'(p.yd);
    r.apx    = 12'(p.skp ? (p.aw + 1) / 2 : p.aw);
    r.alines = 12'(p.ah);
    r.smp    = (p.sx < int'(r.apx) && p.sy < p.ah) ? pattern(p.sx, p.sy) : 24'h0;
    return r;
  endfunction

  // Reference reaction to a vs edge closing frame prev_fp.
  task automatic model_vs();
    res_t r;
    frames_seen++;
    exp_chg = 0;
    if (frames_seen >= 2) begin
      r = model_frame(prev_fp);
      exp_chg = (frames_seen >= 3) &&
                ({r.dots, r.lines, r.apx, r.alines} != {exp_r.dots, exp_r.lines, exp_r.apx, exp_r.alines});
      exp_r     = r;
      exp_valid = 1;
      exp_fc    = frames_seen - 1;
    end
  endtask

  task automatic model_lost(input bit was_reset);
    frames_seen = 0;
    exp_valid   = 0;
    exp_fc      = 0;
    if (was_reset) exp_r = '0;
  endtask

  // Drive cycles [c0,c1) of frame p; vs/hs rise together at cycle 0.
  task automatic gen(input fp_t p, input int c0, input int c1);
    for (int c = c0; c < c1; c++) begin
      int x, y;
      x = c % p.xd;
      y = c / p.xd;
      @(posedge clk); #1;
      if (c == 0) begin
        sample_x = CW'(p.sx);
        sample_y = CW'(p.sy);
        hs_w = $urandom_range(1, 3);
        vs_w = $urandom_range(1, 20);
      end
      if (x == 0) gen_px = 0;
      hs = (x < hs_w);
      vs = (y == 0) && (x < vs_w);
      de = (y >= DY0) && (y < DY0 + p.ah) && (x >= DX0) && (x < DX0 + p.aw);
      if (de) begin
        skip = p.skp && ((x - DX0) % 2 == 1);
        if (skip) rgb = 24'($urandom);
        else begin
          rgb = pattern(gen_px, y - DY0);
          gen_px++;
        end
      end else begin
        skip = 1'($urandom);
        rgb  = 24'($urandom);
      end
    end
  endtask

  // Start frame p; returns at the negedge where the publish is visible.
  task automatic begin_frame(input fp_t p);
    model_vs();
    gen(p, 0, 2);
    @(negedge clk);
  endtask

  task automatic end_frame(input fp_t p, input int c0);
    gen(p, c0, p.xd * p.yd);
    prev_fp = p;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      hs = 0; vs = 0; de = 0; skip = 0; rgb = '0;
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(negedge clk);
    tests++; if (valid !== 1'b0 || changed !== 1'b0) begin fails++; $display("FAIL reset_flags: got valid=%b changed=%b want 0 0", valid, changed); end
    tests++; if (frame_count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", frame_count); end
    tests++; if ({frame_dots, frame_lines, active_px, active_lines, sample_rgb} !== 72'h0) begin fails++;
      $display("FAIL reset_results: got %h want 0", {frame_dots, frame_lines, active_px, active_lines, sample_rgb}); end
    @(posedge clk); #1 reset_n = 1;
    model_lost(1);
  endtask

  task automatic test_lock();
    begin_frame(base);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL lock_measure_valid: got %b want 0", valid); end
    end_frame(base, 2);
    begin_frame(base);
    tests++; if (valid !== exp_valid || frame_count !== FCW'(exp_fc)) begin fails++;
      $display("FAIL lock_first: got valid=%b count=%0d want %b %0d", valid, frame_count, exp_valid, exp_fc); end
    tests++; if ({frame_dots, frame_lines, active_px, active_lines, sample_rgb} !== exp_r) begin fails++;
      $display("FAIL lock_results: got %h want %h", {frame_dots, frame_lines, active_px, active_lines, sample_rgb}, exp_r); end
    tests++; if (changed !== 1'b0) begin fails++; $display("FAIL lock_first_changed: got %b want 0", changed); end
    end_frame(base, 2);
    begin_frame(base);
    tests++; if (frame_count !== FCW'(exp_fc) || changed !== exp_chg) begin fails++;
      $display("FAIL lock_second: got count=%0d changed=%b want %0d %b", frame_count, changed, exp_fc, exp_chg); end
    end_frame(base, 2);
  endtask

  task automatic test_sample();
    int xs[8], ys[8];
    fp_t p;
    xs = '{12, 0, 24, 0, 23, 5, 0, 0};
    ys = '{10, 0, 0, 20, 19, 7, 0, 0};
    xs[6] = $urandom_range(0, 23); ys[6] = $urandom_range(0, 19);
    xs[7] = $urandom_range(0, 26); ys[7] = $urandom_range(0, 22);
    for (int i = 0; i <= 8; i++) begin
      p = base;
      if (i < 8) begin p.sx = xs[i]; p.sy = ys[i]; end
      begin_frame(p);
      tests++; if (sample_rgb !== exp_r.smp) begin fails++;
        $display("FAIL sample_%0d: got %h want %h", i, sample_rgb, exp_r.smp); end
      end_frame(p, 2);
    end
  endtask

  task automatic test_line_change();
    fp_t p;
    p = base;
    p.yd = 30;
    begin_frame(p);
    tests++; if (frame_lines !== exp_r.lines || changed !== exp_chg) begin fails++;
      $display("FAIL lines_before: got %0d/%b want %0d/%b", frame_lines, changed, exp_r.lines, exp_chg); end
    end_frame(p, 2);
    begin_frame(p);
    tests++; if (frame_lines !== exp_r.lines || changed !== exp_chg) begin fails++;
      $display("FAIL lines_after: got %0d/%b want %0d/%b", frame_lines, changed, exp_r.lines, exp_chg); end
    gen(p, 2, 3);
    @(negedge clk);
    tests++; if (changed !== 1'b0) begin fails++; $display("FAIL changed_width: got %b want 0", changed); end
    end_frame(p, 3);
    begin_frame(p);
    tests++; if (changed !== exp_chg) begin fails++; $display("FAIL changed_steady: got %b want %b", changed, exp_chg); end
    end_frame(p, 2);
  endtask

  task automatic test_skip();
    fp_t p;
    p = base;
    p.skp = 1; p.sx = 5; p.sy = 3;
    for (int i = 0; i < 3; i++) begin
      begin_frame(i == 2 ? base : p);
      tests++; if ({frame_dots, frame_lines, active_px, active_lines, sample_rgb} !== exp_r || changed !== exp_chg) begin fails++;
        $display("FAIL skip_%0d: got %h/%b want %h/%b", i, {frame_dots, frame_lines, active_px, active_lines, sample_rgb}, changed, exp_r, exp_chg); end
      end_frame(i == 2 ? base : p, 2);
    end
  endtask

  task automatic test_timeout();
    idle(4000);
    @(negedge clk);
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL timeout_early: got valid=%b want 1", valid); end
    idle(200);
    @(negedge clk);
    model_lost(0);
    tests++; if (valid !== 1'b0 || frame_count !== '0) begin fails++;
      $display("FAIL timeout_drop: got valid=%b count=%0d want 0 0", valid, frame_count); end
    tests++; if ({frame_dots, frame_lines, active_px, active_lines, sample_rgb} !== exp_r) begin fails++;
      $display("FAIL timeout_hold: got %h want %h", {frame_dots, frame_lines, active_px, active_lines, sample_rgb}, exp_r); end
    begin_frame(base);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL timeout_measure: got valid=%b want 0", valid); end
    end_frame(base, 2);
    begin_frame(base);
    tests++; if (valid !== 1'b1 || frame_count !== FCW'(exp_fc) || {frame_dots, frame_lines, active_px, active_lines, sample_rgb} !== exp_r) begin fails++;
      $display("FAIL timeout_relock: got %b/%0d/%h want 1/%0d/%h", valid, frame_count, {frame_dots, frame_lines, active_px, active_lines, sample_rgb}, exp_fc, exp_r); end
    end_frame(base, 2);
  endtask

  task automatic test_reset_midframe();
    int k;
    k = 5 * base.xd + 20;
    begin_frame(base);
    gen(base, 2, k);
    #1 reset_n = 0;
    #1;
    tests++; if (valid !== 1'b0 || changed !== 1'b0 || frame_count !== '0 ||
                 {frame_dots, frame_lines, active_px, active_lines, sample_rgb} !== 72'h0) begin fails++;
      $display("FAIL async_reset: got %b/%b/%0d/%h want all 0", valid, changed, frame_count, {frame_dots, frame_lines, active_px, active_lines, sample_rgb}); end
    gen(base, k, k + 3);
    reset_n = 1;
    model_lost(1);
    end_frame(base, k + 3);
    begin_frame(base);
    tests++; if (valid !== 1'b0 || frame_dots !== '0) begin fails++;
      $display("FAIL reset_measure: got valid=%b dots=%0d want 0 0", valid, frame_dots); end
    end_frame(base, 2);
    begin_frame(base);
    tests++; if (valid !== 1'b1 || frame_count !== FCW'(exp_fc) || changed !== 1'b0 ||
                 {frame_dots, frame_lines, active_px, active_lines, sample_rgb} !== exp_r) begin fails++;
      $display("FAIL reset_relock: got %b/%0d/%b/%h want 1/%0d/0/%h", valid, frame_count, changed, {frame_dots, frame_lines, active_px, active_lines, sample_rgb}, exp_fc, exp_r); end
    end_frame(base, 2);
  endtask

  task automatic test_random();
    fp_t p;
    for (int i = 0; i <= 6; i++) begin
      p = base;
      if (i < 6) begin
        p.xd  = $urandom_range(40, 52);
        p.yd  = $urandom_range(26, 32);
        p.aw  = 2 * $urandom_range(6, 15);
        p.ah  = $urandom_range(8, 18);
        p.skp = 1'($urandom);
        p.sx  = $urandom_range(0, p.aw);
        p.sy  = $urandom_range(0, p.ah + 1);
      end
      begin_frame(p);
      tests++; if (valid !== exp_valid || frame_count !== FCW'(exp_fc) || changed !== exp_chg) begin fails++;
        $display("FAIL random_%0d_status: got %b/%0d/%b want %b/%0d/%b", i, valid, frame_count, changed, exp_valid, exp_fc, exp_chg); end
      tests++; if ({frame_dots, frame_lines, active_px, active_lines, sample_rgb} !== exp_r) begin fails++;
        $display("FAIL random_%0d_results: got %h want %h", i, {frame_dots, frame_lines, active_px, active_lines, sample_rgb}, exp_r); end
      end_frame(p, 2);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    base = '{xd: 40, yd: 28, aw: 24, ah: 20, skp: 1'b0, sx: 0, sy: 0};
    prev_fp = base;
    test_reset();
    test_lock();
    test_sample();
    test_line_change();
    test_skip();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
